// File: rtl/ppc_types.sv
// Shared PowerPC pipeline types: compare decode word and the compare
// reservation-station entry layout.
package ppc_types;

  typedef struct packed {
    logic l_bit;    // 64-bit compare when set
    logic logical;  // unsigned (cmpl) compare when set
  } cmp_decode_t;

  // Entry tags are stored at this width so the struct is parameter-free;
  // narrower tag widths are zero-extended into it.
  localparam int RS_TAG_MAX_W = 8;
  typedef logic [RS_TAG_MAX_W-1:0] rs_tag_t;

  typedef struct packed {
    logic        busy;
    cmp_decode_t control;
    logic [2:0]  cr_addr;
    logic [31:0] op1_value;
    logic        op1_pending;
    rs_tag_t     op1_tag;
    logic [31:0] op2_value;
    logic        op2_pending;
    rs_tag_t     op2_tag;
    logic        so_value;
    logic        so_pending;
    rs_tag_t     so_tag;
  } cmp_rs_entry_t;

  function automatic logic tag_hit(input logic pending, input rs_tag_t stored,
                                   input rs_tag_t bus);
    return pending && (stored == bus);
  endfunction

endpackage

// File: rtl/cmp_reservation_station_priority_encoder.sv
// Lowest-index-set encoder: reports whether any request bit is set and the
// index of the lowest one (zero when none).
module rs_priority_encoder #(
  parameter int WIDTH = 4,
  parameter int IDX_W = 2
) (
  input  logic [WIDTH-1:0] req,
  output logic             found,
  output logic [IDX_W-1:0] index
);

  always_comb begin
    found = |req;
    index = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (req[i]) index = IDX_W'(i);
    end
  end

endmodule

// File: rtl/cmp_reservation_station.sv
// Reservation station for the compare unit: holds dispatched compares until
// their GPR operands and XER[SO] arrive on the result bus, then issues them.
module cmp_reservation_station
  import ppc_types::*;
#(
  parameter int RS_ID_WIDTH = 5,
  parameter int RS_DEPTH    = 4,
  parameter int RS_OFFSET   = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   dispatch_valid,
  output logic                   dispatch_ready,
  output logic [RS_ID_WIDTH-1:0] dispatch_rs_id,
  input  logic [2:0]             result_reg_addr_in,
  input  cmp_decode_t            control_in,
  input  logic [31:0]            op1_value_in,
  input  logic [31:0]            op2_value_in,
  input  logic                   op1_pending,
  input  logic                   op2_pending,
  input  logic [RS_ID_WIDTH-1:0] op1_tag,
  input  logic [RS_ID_WIDTH-1:0] op2_tag,
  input  logic                   so_value_in,
  input  logic                   so_pending,
  input  logic [RS_ID_WIDTH-1:0] so_tag,
  input  logic                   cdb_valid,
  input  logic [RS_ID_WIDTH-1:0] cdb_rs_id,
  input  logic [31:0]            cdb_value,
  input  logic                   cdb_so,
  output logic                   issue_valid,
  input  logic                   issue_ready,
  output logic [RS_ID_WIDTH-1:0] issue_rs_id,
  output logic [2:0]             issue_result_reg_addr,
  output logic [31:0]            issue_op1,
  output logic [31:0]            issue_op2,
  output logic                   issue_so,
  output cmp_decode_t            issue_control
);

  localparam int IDX_W = $clog2(RS_DEPTH);

  if (RS_DEPTH < 2 || RS_DEPTH > 8) begin : g_bad_depth
    $error("cmp_reservation_station: RS_DEPTH must be within 2..8");
  end
  if (RS_OFFSET + RS_DEPTH - 1 >= 2 ** RS_ID_WIDTH) begin : g_bad_offset
    $error("cmp_reservation_station: entry tags exceed RS_ID_WIDTH");
  end
  if (RS_ID_WIDTH > RS_TAG_MAX_W) begin : g_bad_width
    $error("cmp_reservation_station: RS_ID_WIDTH wider than stored tags");
  end

  cmp_rs_entry_t       entry_reg [RS_DEPTH];
  cmp_rs_entry_t       new_entry;
  logic [RS_DEPTH-1:0] free_vec;
  logic [RS_DEPTH-1:0] ready_vec;
  logic [RS_DEPTH-1:0] op1_wake;
  logic [RS_DEPTH-1:0] op2_wake;
  logic [RS_DEPTH-1:0] so_wake;
  logic                alloc_found;
  logic                issue_found;
  logic [IDX_W-1:0]    alloc_idx;
  logic [IDX_W-1:0]    issue_idx;
  logic                dispatch_fire;
  logic                issue_fire;
  rs_tag_t             cdb_tag;

  assign cdb_tag = rs_tag_t'(cdb_rs_id);

  // Per-entry status and result-bus wakeup, all from registered state.
  for (genvar gi = 0; gi < RS_DEPTH; gi++) begin : g_entry
    assign free_vec[gi]  = !entry_reg[gi].busy;
    assign ready_vec[gi] = entry_reg[gi].busy && !entry_reg[gi].op1_pending &&
                           !entry_reg[gi].op2_pending && !entry_reg[gi].so_pending;
    assign op1_wake[gi]  = cdb_valid && entry_reg[gi].busy &&
                           tag_hit(entry_reg[gi].op1_pending, entry_reg[gi].op1_tag, cdb_tag);
    assign op2_wake[gi]  = cdb_valid && entry_reg[gi].busy &&
                           tag_hit(entry_reg[gi].op2_pending, entry_reg[gi].op2_tag, cdb_tag);
    assign so_wake[gi]   = cdb_valid && entry_reg[gi].busy &&
                           tag_hit(entry_reg[gi].so_pending, entry_reg[gi].so_tag, cdb_tag);
  end

  rs_priority_encoder #(.WIDTH(RS_DEPTH), .IDX_W(IDX_W)) u_alloc_enc (
    .req   (free_vec),
    .found (alloc_found),
    .index (alloc_idx)
  );

  rs_priority_encoder #(.WIDTH(RS_DEPTH), .IDX_W(IDX_W)) u_issue_enc (
    .req   (ready_vec),
    .found (issue_found),
    .index (issue_idx)
  );

  assign dispatch_ready = alloc_found;
  assign dispatch_rs_id = RS_ID_WIDTH'(RS_OFFSET) + RS_ID_WIDTH'(alloc_idx);
  assign dispatch_fire  = dispatch_valid && alloc_found;
  assign issue_fire     = issue_found && issue_ready;

  // Incoming op, with any field whose producer broadcasts this same cycle
  // taken straight from the bus so it can never miss its wakeup.
  always_comb begin
    logic op1_byp;
    logic op2_byp;
    logic so_byp;
    op1_byp = cdb_valid && tag_hit(op1_pending, rs_tag_t'(op1_tag), cdb_tag);
    op2_byp = cdb_valid && tag_hit(op2_pending, rs_tag_t'(op2_tag), cdb_tag);
    so_byp  = cdb_valid && tag_hit(so_pending, rs_tag_t'(so_tag), cdb_tag);

    new_entry             = '0;
    new_entry.busy        = 1'b1;
    new_entry.control     = control_in;
    new_entry.cr_addr     = result_reg_addr_in;
    new_entry.op1_value   = op1_byp ? cdb_value : op1_value_in;
    new_entry.op1_pending = op1_pending && !op1_byp;
    new_entry.op1_tag     = rs_tag_t'(op1_tag);
    new_entry.op2_value   = op2_byp ? cdb_value : op2_value_in;
    new_entry.op2_pending = op2_pending && !op2_byp;
    new_entry.op2_tag     = rs_tag_t'(op2_tag);
    new_entry.so_value    = so_byp ? cdb_so : so_value_in;
    new_entry.so_pending  = so_pending && !so_byp;
    new_entry.so_tag      = rs_tag_t'(so_tag);
  end

  // Allocation only targets free entries and issue/wakeup only busy ones,
  // so the branches below never compete for the same entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < RS_DEPTH; i++) begin
        entry_reg[i] <= '0;
      end
    end else begin
      for (int i = 0; i < RS_DEPTH; i++) begin
        if (dispatch_fire && alloc_idx == IDX_W'(i)) begin
          entry_reg[i] <= new_entry;
        end else begin
          if (issue_fire && issue_idx == IDX_W'(i)) begin
            entry_reg[i].busy <= 1'b0;
          end
          if (op1_wake[i]) begin
            entry_reg[i].op1_value   <= cdb_value;
            entry_reg[i].op1_pending <= 1'b0;
          end
          if (op2_wake[i]) begin
            entry_reg[i].op2_value   <= cdb_value;
            entry_reg[i].op2_pending <= 1'b0;
          end
          if (so_wake[i]) begin
            entry_reg[i].so_value   <= cdb_so;
            entry_reg[i].so_pending <= 1'b0;
          end
        end
      end
    end
  end

  assign issue_valid = issue_found;

  always_comb begin
    issue_rs_id           = '0;
    issue_result_reg_addr = '0;
    issue_op1             = '0;
    issue_op2             = '0;
    issue_so              = 1'b0;
    issue_control         = '0;
    if (issue_found) begin
      issue_rs_id           = RS_ID_WIDTH'(RS_OFFSET) + RS_ID_WIDTH'(issue_idx);
      issue_result_reg_addr = entry_reg[issue_idx].cr_addr;
      issue_op1             = entry_reg[issue_idx].op1_value;
      issue_op2             = entry_reg[issue_idx].op2_value;
      issue_so              = entry_reg[issue_idx].so_value;
      issue_control         = entry_reg[issue_idx].control;
    end
  end

endmodule

// File: tb/tb_cmp_reservation_station.sv
// Scoreboard bench for cmp_reservation_station: a slot-level reference model
// predicts every handshake; a negedge monitor pops and compares.
module tb_cmp_reservation_station;
  import ppc_types::*;

  localparam int W   = 5;
  localparam int D   = 4;
  localparam int OFF = 0;

  logic         clk = 1'b0;
  logic         rst;
  logic         dispatch_valid;
  logic         dispatch_ready;
  logic [W-1:0] dispatch_rs_id;
  logic [2:0]   result_reg_addr_in;
  cmp_decode_t  control_in;
  logic [31:0]  op1_value_in, op2_value_in;
  logic         op1_pending, op2_pending;
  logic [W-1:0] op1_tag, op2_tag;
  logic         so_value_in, so_pending;
  logic [W-1:0] so_tag;
  logic         cdb_valid;
  logic [W-1:0] cdb_rs_id;
  logic [31:0]  cdb_value;
  logic         cdb_so;
  logic         issue_valid, issue_ready;
  logic [W-1:0] issue_rs_id;
  logic [2:0]   issue_result_reg_addr;
  logic [31:0]  issue_op1, issue_op2;
  logic         issue_so;
  cmp_decode_t  issue_control;
  logic [1:0]   issue_ctrl_bits;

  assign issue_ctrl_bits = issue_control;

  always #5 clk = ~clk;

  cmp_reservation_station #(.RS_ID_WIDTH(W), .RS_DEPTH(D), .RS_OFFSET(OFF)) dut (
    .clk(clk), .rst(rst),
    .dispatch_valid(dispatch_valid), .dispatch_ready(dispatch_ready),
    .dispatch_rs_id(dispatch_rs_id), .result_reg_addr_in(result_reg_addr_in),
    .control_in(control_in), .op1_value_in(op1_value_in), .op2_value_in(op2_value_in),
    .op1_pending(op1_pending), .op2_pending(op2_pending),
    .op1_tag(op1_tag), .op2_tag(op2_tag),
    .so_value_in(so_value_in), .so_pending(so_pending), .so_tag(so_tag),
    .cdb_valid(cdb_valid), .cdb_rs_id(cdb_rs_id), .cdb_value(cdb_value), .cdb_so(cdb_so),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_rs_id(issue_rs_id),
    .issue_result_reg_addr(issue_result_reg_addr), .issue_op1(issue_op1),
    .issue_op2(issue_op2), .issue_so(issue_so), .issue_control(issue_control)
  );

  // Reference model: each slot holds an op's operands (0=op1, 1=op2, 2=so).
  typedef struct {
    bit        busy;
    bit [1:0]  ctrl;
    bit [2:0]  cr;
    bit [31:0] v[3];
    bit        pend[3];
    bit [4:0]  tag[3];
  } slot_t;

  typedef struct {
    bit [4:0]  id;
    bit [2:0]  cr;
    bit [1:0]  ctrl;
    bit [31:0] op1, op2;
    bit        so;
  } exp_t;

  typedef struct {
    bit        dv;
    bit [2:0]  cr;
    bit [1:0]  ctrl;
    bit [31:0] v1, v2;
    bit        p1, p2;
    bit [4:0]  t1, t2;
    bit        so, ps;
    bit [4:0]  ts;
    bit        cv;
    bit [4:0]  cid;
    bit [31:0] cval;
    bit        cso;
    bit        ir;
  } stim_t;

  slot_t    m [D];
  exp_t     exp_q[$];
  int       n_checks = 0;
  int       n_fail = 0;
  bit       exp_dready;
  bit [4:0] exp_did;
  bit       exp_ivalid;
  bit [4:0] exp_iid;
  bit       mon_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
    end
  endtask

  function automatic int lowest_free();
    for (int i = 0; i < D; i++) if (!m[i].busy) return i;
    return -1;
  endfunction

  function automatic int lowest_ready();
    for (int i = 0; i < D; i++)
      if (m[i].busy && !m[i].pend[0] && !m[i].pend[1] && !m[i].pend[2]) return i;
    return -1;
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < D; i++) m[i] = '{default: '0};
  endfunction

  // Effect of one clock edge, using the inputs still applied to the DUT.
  function automatic void model_edge();
    int    fi;
    int    ri;
    slot_t s;
    bit    pin[3];
    bit [4:0] tin[3];
    fi = lowest_free();
    ri = lowest_ready();
    if (ri >= 0 && issue_ready) m[ri].busy = 0;
    if (cdb_valid)
      for (int i = 0; i < D; i++)
        for (int f = 0; f < 3; f++)
          if (m[i].busy && m[i].pend[f] && m[i].tag[f] == cdb_rs_id) begin
            m[i].pend[f] = 0;
            m[i].v[f] = (f == 2) ? {31'b0, cdb_so} : cdb_value;
          end
    if (dispatch_valid && fi >= 0) begin
      s = '{default: '0};
      s.busy = 1; s.ctrl = control_in; s.cr = result_reg_addr_in;
      s.v[0] = op1_value_in; s.v[1] = op2_value_in; s.v[2] = {31'b0, so_value_in};
      pin[0] = op1_pending; pin[1] = op2_pending; pin[2] = so_pending;
      tin[0] = op1_tag; tin[1] = op2_tag; tin[2] = so_tag;
      for (int f = 0; f < 3; f++) begin
        s.tag[f] = tin[f];
        s.pend[f] = pin[f];
        if (pin[f] && cdb_valid && cdb_rs_id == tin[f]) begin
          s.pend[f] = 0;
          s.v[f] = (f == 2) ? {31'b0, cdb_so} : cdb_value;
        end
      end
      m[fi] = s;
    end
  endfunction

  function automatic void model_expect();
    int fi;
    int ri;
    fi = lowest_free();
    ri = lowest_ready();
    exp_dready = (fi >= 0);
    exp_did    = 5'(OFF + ((fi >= 0) ? fi : 0));
    exp_ivalid = (ri >= 0);
    exp_iid    = 5'(OFF + ((ri >= 0) ? ri : 0));
  endfunction

  task automatic drive(input stim_t s);
    int   ri;
    exp_t e;
    dispatch_valid = s.dv; result_reg_addr_in = s.cr; control_in = cmp_decode_t'(s.ctrl);
    op1_value_in = s.v1; op2_value_in = s.v2; op1_pending = s.p1; op2_pending = s.p2;
    op1_tag = s.t1; op2_tag = s.t2; so_value_in = s.so; so_pending = s.ps; so_tag = s.ts;
    cdb_valid = s.cv; cdb_rs_id = s.cid; cdb_value = s.cval; cdb_so = s.cso;
    issue_ready = s.ir;
    ri = lowest_ready();
    if (ri >= 0 && s.ir) begin
      e.id = 5'(OFF + ri); e.cr = m[ri].cr; e.ctrl = m[ri].ctrl;
      e.op1 = m[ri].v[0]; e.op2 = m[ri].v[1]; e.so = m[ri].v[2][0];
      exp_q.push_back(e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    model_edge();
    model_expect();
  endtask

  task automatic step(input stim_t s);
    drive(s);
    tick();
  endtask

  function automatic stim_t idle(input bit ir);
    stim_t s;
    s = '{default: '0};
    s.ir = ir;
    return s;
  endfunction

  function automatic stim_t disp(input bit [31:0] a, input bit [31:0] b, input bit ir);
    stim_t s;
    s = idle(ir);
    s.dv = 1; s.v1 = a; s.v2 = b; s.cr = 3'(a[2:0] ^ b[2:0]); s.ctrl = 2'(a[1:0]);
    return s;
  endfunction

  task automatic sync_after_reset();
    @(posedge clk);
    #1;
    model_clear();
    exp_q.delete();
    model_expect();
    mon_en = 1'b1;
  endtask

  // Monitor: compares the DUT against the model's expectations mid-cycle.
  always @(negedge clk) begin
    if (mon_en) begin
      check("dispatch_ready", 32'(dispatch_ready), 32'(exp_dready));
      if (exp_dready) check("dispatch_rs_id", 32'(dispatch_rs_id), 32'(exp_did));
      check("issue_valid", 32'(issue_valid), 32'(exp_ivalid));
      if (issue_valid && issue_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_issue", 32'(issue_rs_id), 32'hFFFF_FFFF);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("issue_rs_id", 32'(issue_rs_id), 32'(e.id));
          check("issue_op1", issue_op1, e.op1);
          check("issue_op2", issue_op2, e.op2);
          check("issue_so", 32'(issue_so), 32'(e.so));
          check("issue_cr", 32'(issue_result_reg_addr), 32'(e.cr));
          check("issue_control", 32'(issue_ctrl_bits), 32'(e.ctrl));
          $display("issue id=%0d op1=%h op2=%h so=%0b cr=%0d", issue_rs_id,
                   issue_op1, issue_op2, issue_so, issue_result_reg_addr);
        end
      end else if (issue_valid) begin
        check("stall_issue_rs_id", 32'(issue_rs_id), 32'(exp_iid));
      end else if (issue_ready && exp_q.size() != 0) begin
        void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    stim_t s;
    rst = 1'b1;
    drive(idle(0));
    #1;
    check("reset_dispatch_ready", 32'(dispatch_ready), 32'd1);
    check("reset_dispatch_rs_id", 32'(dispatch_rs_id), 32'(OFF));
    check("reset_issue_valid", 32'(issue_valid), 32'd0);
    check("reset_issue_op1", issue_op1, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    sync_after_reset();

    // Operands present: issue one cycle after dispatch.
    step(disp(32'd5, 32'd7, 1));
    step(idle(1));
    step(idle(1));

    // op2 waits on tag 9, broadcast three cycles later.
    s = disp(32'h10, 32'h0, 1); s.p2 = 1; s.t2 = 5'd9;
    step(s);
    step(idle(1));
    step(idle(1));
    s = idle(1); s.cv = 1; s.cid = 5'd9; s.cval = 32'hFFFF_FFFF;
    step(s);
    step(idle(1));
    step(idle(1));

    // Same-cycle bypass of op1 tag 12.
    s = disp(32'h0, 32'h22, 1); s.p1 = 1; s.t1 = 5'd12; s.cv = 1; s.cid = 5'd12; s.cval = 32'd3;
    step(s);
    step(idle(1));
    step(idle(1));

    // Fill all entries with no issue, then free entry 0 with one handshake.
    for (int i = 0; i < D; i++) step(disp(32'(100 + i), 32'(200 + i), 0));
    step(disp(32'hDEAD, 32'hBEEF, 0));
    s = disp(32'hDEAD, 32'hBEEF, 1);
    step(s);
    step(disp(32'd300, 32'd301, 0));
    for (int i = 0; i < 8; i++) step(idle(1));

    // Entries 1 and 3 ready, 0 and 2 waiting; stall five cycles.
    s = disp(32'd1, 32'd1, 0); s.ps = 1; s.ts = 5'd20; step(s);
    step(disp(32'd2, 32'd2, 0));
    s = disp(32'd3, 32'd3, 0); s.p1 = 1; s.t1 = 5'd21; step(s);
    step(disp(32'd4, 32'd4, 0));
    for (int i = 0; i < 5; i++) step(idle(0));
    step(idle(1));
    step(idle(1));
    s = idle(1); s.cv = 1; s.cid = 5'd20; s.cso = 1; step(s);
    s = idle(1); s.cv = 1; s.cid = 5'd21; s.cval = 32'h5A5A_5A5A; step(s);
    for (int i = 0; i < 4; i++) step(idle(1));

    // Asynchronous reset between edges with three busy entries.
    for (int i = 0; i < 3; i++) step(disp(32'(40 + i), 32'(50 + i), 0));
    drive(idle(0));
    #2;
    mon_en = 1'b0;
    rst = 1'b1;
    #1;
    check("midrst_dispatch_ready", 32'(dispatch_ready), 32'd1);
    check("midrst_dispatch_rs_id", 32'(dispatch_rs_id), 32'(OFF));
    check("midrst_issue_valid", 32'(issue_valid), 32'd0);
    @(negedge clk);
    drive(idle(1));
    rst = 1'b0;
    sync_after_reset();
    for (int i = 0; i < 4; i++) step(idle(1));

    // Randomized traffic.
    for (int c = 0; c < 500; c++) begin
      s = idle($urandom_range(3) != 0);
      s.dv   = ($urandom_range(2) != 0);
      s.v1   = $urandom; s.v2 = $urandom; s.so = 1'($urandom);
      s.cr   = 3'($urandom); s.ctrl = 2'($urandom);
      s.p1   = ($urandom_range(2) == 0); s.t1 = 5'(8 + $urandom_range(3));
      s.p2   = ($urandom_range(2) == 0); s.t2 = 5'(8 + $urandom_range(3));
      s.ps   = ($urandom_range(3) == 0); s.ts = 5'(8 + $urandom_range(3));
      s.cv   = 1'($urandom);
      s.cid  = 5'(8 + $urandom_range(4));
      s.cval = $urandom; s.cso = 1'($urandom);
      step(s);
    end

    // Drain: broadcast every producer tag until all ops have issued.
    for (int c = 0; c < 40; c++) begin
      s = idle(1); s.cv = 1; s.cid = 5'(8 + (c % 4)); s.cval = $urandom; s.cso = 1'($urandom);
      step(s);
    end
    step(idle(1));
    check("drain_scoreboard_empty", 32'(exp_q.size()), 32'd0);
    check("drain_issue_valid", 32'(issue_valid), 32'd0);
    check("drain_dispatch_ready", 32'(dispatch_ready), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
